// File: rtl/ring_fifo.sv
// Circular first-word-fall-through FIFO with a registered element count, level flags,
// sticky overflow/underflow error flags and a synchronous flush. Any depth >= 2.
module ring_fifo #(
  parameter int BUFFER_WIDTH = 16,
  parameter int BUFFER_DEPTH = 8,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2,
  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1,
  localparam int CW = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pull,
  input  logic [BUFFER_WIDTH-1:0] tail,
  output logic [BUFFER_WIDTH-1:0] head,
  output logic [CW-1:0]           counter,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);
  localparam logic [PW-1:0] LAST_C  = PW'(BUFFER_DEPTH - 1);

  logic [BUFFER_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic                    push_ok;
  logic                    pull_ok;

  // Explicit wrap so that non-power-of-two depths cycle through exactly DEPTH slots.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_C) ? '0 : ptr + PW'(1);
  endfunction

  assign full         = (counter == DEPTH_C);
  assign empty        = (counter == '0);
  assign almost_full  = (counter >= AF_C);
  assign almost_empty = (counter <= AE_C);

  // A push at full is still taken when a pull frees the head slot in the same edge.
  assign push_ok = push & (~full | pull);
  assign pull_ok = pull & ~empty;

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      counter   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      counter   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pull_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pull_ok})
        2'b10:   counter <= counter + CW'(1);
        2'b01:   counter <= counter - CW'(1);
        default: counter <= counter;
      endcase
      if (push & full & ~pull) overflow  <= 1'b1;
      if (pull & empty)        underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; only the pointers give it meaning.
  always_ff @(posedge clock) begin
    if (reset && !clear && push_ok) mem[wr_ptr] <= tail;
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!reset) counter <= DEPTH_C);
  a_flags_excl  : assert property (@(posedge clock) disable iff (!reset) !(full && empty));

endmodule
